// File: rtl/rob_multiport_if.sv
// Dispatch, completion and retire bus between rename/FUs/commit and the reorder buffer.
interface rob_multiport_if #(
    parameter int DEPTH    = 16,
    parameter int NUM_CP   = 3,
    parameter int RETIRE_W = 2,
    parameter int PREG_W   = 7,
    parameter int DATA_W   = 32
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                       flush;
    logic                       disp_valid;
    logic                       disp_ready;
    logic [PREG_W-1:0]          disp_preg_dst;
    logic [PREG_W-1:0]          disp_old_preg_dst;
    logic                       disp_reg_write;
    logic                       disp_mem_write;
    logic [IDX_W-1:0]           disp_rob_id;
    logic [NUM_CP-1:0]          cp_valid;
    logic [NUM_CP*IDX_W-1:0]    cp_rob_id;
    logic [NUM_CP*DATA_W-1:0]   cp_data;
    logic [RETIRE_W-1:0]        ret_valid;
    logic [RETIRE_W*PREG_W-1:0] ret_preg_dst;
    logic [RETIRE_W*PREG_W-1:0] ret_old_preg_dst;
    logic [RETIRE_W*DATA_W-1:0] ret_data;
    logic [RETIRE_W-1:0]        ret_reg_write;
    logic [RETIRE_W-1:0]        ret_mem_write;
    logic [IDX_W:0]             count;

    modport master (
        output flush, disp_valid, disp_preg_dst, disp_old_preg_dst, disp_reg_write,
               disp_mem_write, cp_valid, cp_rob_id, cp_data,
        input  disp_ready, disp_rob_id, ret_valid, ret_preg_dst, ret_old_preg_dst,
               ret_data, ret_reg_write, ret_mem_write, count
    );

    modport slave (
        input  flush, disp_valid, disp_preg_dst, disp_old_preg_dst, disp_reg_write,
               disp_mem_write, cp_valid, cp_rob_id, cp_data,
        output disp_ready, disp_rob_id, ret_valid, ret_preg_dst, ret_old_preg_dst,
               ret_data, ret_reg_write, ret_mem_write, count
    );
endinterface

// File: rtl/rob_multiport.sv
// Parametrised reorder buffer: one dispatch, NUM_CP completions and up to
// RETIRE_W in-order retirements per cycle, with a global synchronous flush.
module rob_multiport #(
    parameter int DEPTH    = 16,
    parameter int NUM_CP   = 3,
    parameter int RETIRE_W = 2,
    parameter int PREG_W   = 7,
    parameter int DATA_W   = 32
) (
    input logic             clk,
    input logic             reset,
    rob_multiport_if.slave  rb
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]    ent_valid;
    logic [DEPTH-1:0]    ent_complete;
    logic [DEPTH-1:0]    ent_reg_write;
    logic [DEPTH-1:0]    ent_mem_write;
    logic [PREG_W-1:0]   ent_preg [DEPTH];
    logic [PREG_W-1:0]   ent_old  [DEPTH];
    logic [DATA_W-1:0]   ent_data [DEPTH];
    logic [IDX_W-1:0]    head;
    logic [IDX_W-1:0]    tail;
    logic [IDX_W:0]      count;

    logic [RETIRE_W-1:0] ret_mask;
    logic [IDX_W:0]      num_ret;
    logic [IDX_W-1:0]    ret_idx [RETIRE_W];
    logic                run;
    logic                disp_fire;

    // Retire window is built only from registered state, so a completion
    // becomes retirable one cycle after it is written.
    always_comb begin
        ret_mask = '0;
        num_ret  = '0;
        run      = !rb.flush;
        for (int k = 0; k < RETIRE_W; k++) begin
            ret_idx[k] = head + IDX_W'(k);
            if (run && ((IDX_W+1)'(k) < count) && ent_valid[ret_idx[k]] && ent_complete[ret_idx[k]]) begin
                ret_mask[k] = 1'b1;
                num_ret     = num_ret + (IDX_W+1)'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        rb.ret_valid        = ret_mask;
        rb.ret_preg_dst     = '0;
        rb.ret_old_preg_dst = '0;
        rb.ret_data         = '0;
        rb.ret_reg_write    = '0;
        rb.ret_mem_write    = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (ret_mask[k]) begin
                rb.ret_preg_dst[k*PREG_W +: PREG_W]     = ent_preg[ret_idx[k]];
                rb.ret_old_preg_dst[k*PREG_W +: PREG_W] = ent_old[ret_idx[k]];
                rb.ret_data[k*DATA_W +: DATA_W]         = ent_data[ret_idx[k]];
                rb.ret_reg_write[k]                     = ent_reg_write[ret_idx[k]];
                rb.ret_mem_write[k]                     = ent_mem_write[ret_idx[k]];
            end
        end
    end

    assign rb.disp_ready  = (count < (IDX_W+1)'(DEPTH));
    assign rb.disp_rob_id = tail;
    assign rb.count       = count;
    assign disp_fire      = rb.disp_valid && rb.disp_ready && !rb.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid     <= '0;
            ent_complete  <= '0;
            ent_reg_write <= '0;
            ent_mem_write <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_preg[i] <= '0;
                ent_old[i]  <= '0;
                ent_data[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rb.flush) begin
            ent_valid    <= '0;
            ent_complete <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else begin
            // Highest port first so the lowest-numbered port's write lands last.
            for (int p = NUM_CP - 1; p >= 0; p--) begin
                if (rb.cp_valid[p] && ent_valid[rb.cp_rob_id[p*IDX_W +: IDX_W]]) begin
                    ent_complete[rb.cp_rob_id[p*IDX_W +: IDX_W]] <= 1'b1;
                    ent_data[rb.cp_rob_id[p*IDX_W +: IDX_W]]     <= rb.cp_data[p*DATA_W +: DATA_W];
                end
            end
            for (int k = 0; k < RETIRE_W; k++) begin
                if (ret_mask[k]) begin
                    ent_valid[ret_idx[k]]    <= 1'b0;
                    ent_complete[ret_idx[k]] <= 1'b0;
                end
            end
            if (disp_fire) begin
                ent_valid[tail]     <= 1'b1;
                ent_complete[tail]  <= 1'b0;
                ent_preg[tail]      <= rb.disp_preg_dst;
                ent_old[tail]       <= rb.disp_old_preg_dst;
                ent_reg_write[tail] <= rb.disp_reg_write;
                ent_mem_write[tail] <= rb.disp_mem_write;
            end
            head  <= head + num_ret[IDX_W-1:0];
            tail  <= tail + IDX_W'(disp_fire);
            count <= count + (IDX_W+1)'(disp_fire) - num_ret;
        end
    end
endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised reorder buffer for the out-of-order core; successor to the fixed 16-row ROB row format.
- Takes one dispatch per cycle from rename, and NUM_CP completion writebacks per cycle from the functional units.
- Retires up to RETIRE_W oldest completed entries per cycle, in program order, to the architectural commit / free-list logic.
- Adds a global flush.

Parameters:
DEPTH, 16, number of entries; power of 2, >=4
IDX_W, $clog2(DEPTH), ROB index width (derived, do not override)
NUM_CP, 3, completion ports (FU1, FU2, FU3-mem)
RETIRE_W, 2, max retirements per cycle, 1..DEPTH
PREG_W, 7, physical register address width
DATA_W, 32, result width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
flush  in  1  synchronous squash of every entry
disp_valid  in  1  rename presents an instruction
disp_ready  out  1  entry available (count < DEPTH)
disp_preg_dst  in  PREG_W  new destination physical reg
disp_old_preg_dst  in  PREG_W  previous mapping, freed at retire
disp_reg_write  in  1  instruction writes a register
disp_mem_write  in  1  instruction is a store
disp_rob_id  out  IDX_W  index assigned (= tail), valid with disp_valid&&disp_ready
cp_valid  in  NUM_CP  per-port completion strobe
cp_rob_id  in  NUM_CP*IDX_W  per-port target index, port p at [p*IDX_W +: IDX_W]
cp_data  in  NUM_CP*DATA_W  per-port result
ret_valid  out  RETIRE_W  slot k retires this cycle
ret_preg_dst  out  RETIRE_W*PREG_W  retiring destination preg
ret_old_preg_dst  out  RETIRE_W*PREG_W  preg to return to free list
ret_data  out  RETIRE_W*DATA_W  retiring result
ret_reg_write  out  RETIRE_W  copied from entry
ret_mem_write  out  RETIRE_W  copied from entry
count  out  IDX_W+1  occupied entries

Behaviour:
- State: per entry valid, complete, preg_dst, old_preg_dst, data, reg_write, mem_write; head, tail (IDX_W, wrap modulo DEPTH); count register.
- Reset (async): all valid/complete=0, head=tail=0, count=0. Outputs: disp_ready=1, disp_rob_id=0, ret_valid=0, count=0; other ret_* buses=0.
- disp_ready = (count < DEPTH), from registered count only. Dispatch fires on disp_valid&&disp_ready: at the edge, entry[tail] is written valid=1, complete=0, then tail+1. disp_rob_id = tail, combinational.
- Completion: for each port with cp_valid and entry[cp_rob_id].valid, set complete=1 and data at the edge. Completion to an invalid entry is ignored.
- Two ports targeting the same index in one cycle: lowest port number's data wins.
- Completion is visible to retire the next cycle; a zero-cycle complete->retire path is forbidden.
- Retire is combinational from registered state. ret_valid[k]=1 iff k < count and entries head..head+k are all valid&&complete; slots are contiguous from 0, so no gaps.
- On the edge, the retired entries are cleared and head += number retired. No backpressure on retire.
- count_next = count + dispatch_fire - num_retired. Simultaneous dispatch and retire are both legal.
- Full: disp_ready=0 even if retire frees entries that cycle (one-cycle bubble accepted).
- Empty: ret_valid=0.
- Wrap: head/tail roll DEPTH-1 -> 0; retire window wraps across index DEPTH-1 -> 0 seamlessly.
- flush=1:
  - ret_valid forced 0.
  - Dispatch and completions ignored.
  - At the edge, all valid/complete=0, head=tail=0, count=0.
  - disp_ready follows the registered count (may be 1), but nothing is written.
- Reset asserted mid-operation: immediate async clear; first dispatch after deassert gets id 0.

Test Plan:
- Reset, dispatch 3 (preg 10,11,12; old 1,2,3), complete ids 0,1,2 on ports 0,1,2 with data 0xA,0xB,0xC in one cycle -> next cycle ret_valid=2'b11 (preg 10/11, old 1/2, data 0xA/0xB); following cycle ret_valid=2'b01, preg 12, data 0xC; count 0.
- Out-of-order: dispatch ids 0,1; complete id1 only -> ret_valid=0 for 5 cycles; complete id0 -> next cycle both retire in order.
- Fill 16 without completion -> disp_ready=0, count=16, extra disp_valid not accepted (tail unchanged); complete id0, retire it -> disp_ready=1 the cycle after.
- Wrap: cycle 20 instructions with immediate completion -> ids go 14,15,0,1; retire across the 15->0 boundary in one cycle, with the correct order.
- Port conflict: ports 0 and 2 both complete id 5 with data 0x11/0x22 -> retired data 0x11; completion to an invalid id 9 -> no state change.
- Flush with 6 entries, 2 complete -> ret_valid=0 that cycle, count=0 next cycle, next dispatch gets id 0; async reset pulse mid-stream -> same clear, no clock needed.
